mac_array_accum: RTL
====================

Name: mac_array_accum

Overview:
- 4x4 grid of 8-bit multiply-accumulate cells directly downstream of the MAC operand controller.
- Each cycle it consumes one broadcast operand slice per cell and accumulates 4 products per matrix result, C = A x B.
- When the controller signals done, it snapshots the 16 sums into a result buffer.
- The buffer is streamed out one row per beat over a valid/ready interface to the writeback stage.

Parameters:
ACC_W, 18, accumulator and result element width in bits (minimum 16; 18 is lossless for unsigned 8x8x4).
SIGNED, 0, 0 = operands unsigned, 1 = operands two's-complement, sign-extended to ACC_W before accumulate.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
en  input  1  tied to the controller enable; cells advance only when high
start  input  1  controller start; first k-step of a new product when high
done  input  1  controller done; previous product complete in the accumulators
mac_ina  input  128  16 x 8-bit A operands; cell (r,c) at bits [(r*4+c)*8 +: 8]
mac_inb  input  128  16 x 8-bit B operands; same packing
out_valid  output  1  result row available
out_ready  input  1  downstream accepts row
out_row  output  2  index of the row on out_data
out_data  output  4*ACC_W  row elements; column c at [c*ACC_W +: ACC_W]
out_last  output  1  high with row 3
overflow  output  1  sticky: a completed result was dropped because the buffer was busy

Behaviour:
- Reset (synchronous; takes priority, including mid-accumulate or mid-stream): all accumulators 0, buffer empty, out_valid 0, out_row 0, out_data 0, out_last 0, overflow 0.
- Accumulate, per cell, on every clk with en=1:
  - p = ina*inb. The product is the 16-bit unsigned product, or the signed product when SIGNED=1, extended to ACC_W.
  - acc <= start ? p : acc + p.
  - Sums wrap modulo 2^ACC_W.
  - With en=0, acc holds.
- Capture:
  - Condition: en && done. In that cycle the accumulators hold the complete sum of k=0..3.
  - On capture, all 16 acc values (pre-update) are copied into the buffer. In the same cycle the accumulators reload from the start product.
  - Capture is allowed if the buffer is empty, or if the final row (row 3) is being accepted in that same cycle.
  - Otherwise the new result is dropped, overflow <= 1 (sticky until reset), and the buffer is unchanged.
- Output FSM states: EMPTY, STREAM.
  - EMPTY -> STREAM on capture. out_valid=1 and out_row=0 are registered, visible the cycle after capture (latency 1 from the done cycle).
  - STREAM: out_data = buffer row out_row. out_last = (out_row==3).
  - A beat transfers when out_valid && out_ready. On transfer out_row increments.
  - Transfer with out_row==3: out_row -> 0. Then either stay in STREAM (simultaneous capture, new buffer contents) or go to EMPTY (out_valid 0).
  - out_valid, out_row and out_data stay stable while out_valid && !out_ready.
- en does not gate the output stream; streaming proceeds with en=0.

Test Plan:
1. Identity:
   - Stimulus: A = identity, B[k][c] = 4k+c+1, slices driven for k=0..3 with start at k=0, then done.
   - Response: 4 beats, out_row 0..3, row r = {4r+1..4r+4}, out_last on beat 4, overflow 0.
2. Max unsigned:
   - Stimulus: all A = B = 255, SIGNED=0.
   - Response: every element 260100 (0x3F804), no wrap at ACC_W=18.
3. Signed:
   - Stimulus: SIGNED=1, A all 0x80 (-128), B all 0x7F (127).
   - Response: every element -65024 in ACC_W two's complement.
4. Backpressure and stall:
   - Stimulus: out_ready low for 5 cycles after out_valid rises, then toggled every cycle; en dropped for 2 cycles mid-accumulate.
   - Response: out_data and out_row are held stable while stalled; results are identical to the unstalled run.
5. Back-to-back with overflow:
   - Stimulus: two consecutive products with out_ready held 0.
   - Response: first result retained, second dropped, overflow rises in the second done cycle and stays high.
   - Stimulus: repeat with out_ready=1 so row 3 is accepted in the second done cycle.
   - Response: second result captured, no overflow.
6. Reset mid-operation:
   - Stimulus: reset asserted at k=2 and again mid-stream at out_row=1.
   - Response: out_valid 0 and out_row 0 next cycle; the following product computes correctly from zeroed accumulators.

Source files
------------

// File: rtl/mac_array_accum_if.sv
// Result-row stream from the MAC array to the writeback stage.
//   out_valid : a result row is presented
//   out_ready : downstream accepts the presented row this cycle
//   out_row   : index (0..3) of the row on out_data
//   out_data  : four ACC_W elements, column c at [c*ACC_W +: ACC_W]
//   out_last  : high while row 3 is presented
// master = the array (producer), slave = the writeback stage (consumer).
interface mac_array_accum_if #(
  parameter int ACC_W = 18
);
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_row;
  logic [4*ACC_W-1:0] out_data;
  logic               out_last;

  modport master (
    output out_valid,
    output out_row,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_row,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mac_array_accum.sv
// 4x4 multiply-accumulate array with a one-deep result buffer.
// Each cell (r,c) multiplies its broadcast operand pair and accumulates;
// on en && done the 16 finished sums are snapshotted into the buffer and
// streamed out one row per beat on the valid/ready interface.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   en               : cells (and capture) advance only when high
//   start            : first k-step of a new product (acc reloads)
//   done             : accumulators hold a complete product this cycle
//   mac_ina, mac_inb : 16 x 8-bit operands, cell (r,c) at [(r*4+c)*8 +: 8]
//   out_if           : result row stream (master side)
//   overflow         : sticky, a finished result was dropped (buffer busy)
module mac_array_accum #(
  parameter int ACC_W  = 18,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic                 done,
  input  logic [127:0]         mac_ina,
  input  logic [127:0]         mac_inb,
  mac_array_accum_if.master    out_if,
  output logic                 overflow
);

  typedef enum logic {EMPTY, STREAM} state_t;

  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic             overflow_q, overflow_d;
  logic [ACC_W-1:0] acc_vec [16];
  logic [ACC_W-1:0] buf_q [16];

  logic capture_req;
  logic final_accept;
  logic capture;

  assign capture_req  = en & done;
  // The buffer frees up in the same cycle its last row is taken, so a
  // result finishing exactly then can still be captured.
  assign final_accept = (state_q == STREAM) & out_if.out_ready & (row_q == 2'd3);
  assign capture      = capture_req & ((state_q == EMPTY) | final_accept);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cell
      logic [7:0]       a;
      logic [7:0]       b;
      logic [ACC_W-1:0] p_ext;
      logic [ACC_W-1:0] acc_q, acc_d;

      assign a = mac_ina[gi*8 +: 8];
      assign b = mac_inb[gi*8 +: 8];

      if (SIGNED) begin : g_signed
        logic signed [15:0] ps;
        // 8x8 signed product fits exactly in 16 bits; the cast sign-extends.
        assign ps    = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
        assign p_ext = ACC_W'(ps);
      end else begin : g_unsigned
        logic [15:0] pu;
        assign pu    = {8'd0, a} * {8'd0, b};
        assign p_ext = ACC_W'(pu);
      end

      always_comb begin
        acc_d = acc_q;
        if (en) begin
          acc_d = start ? p_ext : acc_q + p_ext;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end

      assign acc_vec[gi] = acc_q;
    end
  endgenerate

  // Snapshot takes the pre-update accumulator values.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < 16; i++) begin
        buf_q[i] <= acc_vec[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    overflow_d = overflow_q;
    case (state_q)
      EMPTY: begin
        if (capture) begin
          state_d = STREAM;
          row_d   = 2'd0;
        end
      end
      STREAM: begin
        if (out_if.out_ready) begin
          if (row_q == 2'd3) begin
            row_d   = 2'd0;
            state_d = capture ? STREAM : EMPTY;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (capture_req && !capture) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      row_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  // Data is forced to zero while nothing is presented so the buffer never
  // needs a reset of its own.
  always_comb begin
    out_if.out_data = '0;
    for (int c = 0; c < 4; c++) begin
      if (state_q == STREAM) begin
        out_if.out_data[c*ACC_W +: ACC_W] = buf_q[{row_q, 2'(c)}];
      end
    end
  end

  assign out_if.out_valid = (state_q == STREAM);
  assign out_if.out_row   = row_q;
  assign out_if.out_last  = (state_q == STREAM) && (row_q == 2'd3);
  assign overflow         = overflow_q;

endmodule
